// File: rtl/gowin_dsp_pkg.sv
// Shared constants and helpers for the Gowin DSP storage blocks.
package gowin_dsp_pkg;

    localparam int READ_MODE_BYPASS = 0;
    localparam int READ_MODE_PIPE   = 1;

    function automatic int nbytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/gowin_sdp_core.sv
// Simple dual-port array with byte-enable writes and a registered stage-1 read
// whose read-during-write result is fixed up by a registered bypass mux.
module gowin_sdp_core
    import gowin_dsp_pkg::*;
#(
    parameter int DATA_W  = 18,
    parameter int ADDR_W  = 8,
    parameter int BYTE_W  = 9,
    parameter int RDW_NEW = 0,
    localparam int NBYTES = nbytes(DATA_W, BYTE_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [NBYTES-1:0] wbe_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] ra_i,
    output logic [DATA_W-1:0] rd_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] arr_q;
    logic              col_q;
    logic              col_d;
    logic [NBYTES-1:0] byp_be_q;
    logic [DATA_W-1:0] byp_din_q;

    assign col_d = (RDW_NEW != 0) && we_i && (wa_i == ra_i);

    // NOTE: the array has no reset so it maps onto BSRAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wbe_i[i]) mem_q[wa_i][i*BYTE_W +: BYTE_W] <= din_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // NOTE: non-blocking assignments make a same-edge read of mem_q see the pre-write word;
    // the new-data variant is rebuilt from registered write data instead of touching the array path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arr_q     <= '0;
            col_q     <= 1'b0;
            byp_be_q  <= '0;
            byp_din_q <= '0;
        end else if (re_i) begin
            arr_q     <= mem_q[ra_i];
            col_q     <= col_d;
            byp_be_q  <= wbe_i;
            byp_din_q <= din_i;
        end
    end

    always_comb begin
        rd_o = arr_q;
        if (col_q) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byp_be_q[i]) rd_o[i*BYTE_W +: BYTE_W] = byp_din_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/gowin_sdp_ram_pipe.sv
// Parametrised simple dual-port BSRAM with optional output register and read-valid flag.
module gowin_sdp_ram_pipe
    import gowin_dsp_pkg::*;
#(
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 8,
    parameter int BYTE_W    = 9,
    parameter int READ_MODE = READ_MODE_BYPASS,
    parameter int RDW_NEW   = 0,
    localparam int NBYTES   = nbytes(DATA_W, BYTE_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [NBYTES-1:0] wbe,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    input  logic              oce,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $error("gowin_sdp_ram_pipe: DATA_W (%0d) must be a multiple of BYTE_W (%0d)", DATA_W, BYTE_W);
    end
    if (READ_MODE > READ_MODE_PIPE) begin : g_bad_mode
        $error("gowin_sdp_ram_pipe: READ_MODE (%0d) must be 0 or 1", READ_MODE);
    end

    logic [DATA_W-1:0] rd1;
    logic              v1_q;

    gowin_sdp_core #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYTE_W  (BYTE_W),
        .RDW_NEW (RDW_NEW)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .we_i   (we),
        .wa_i   (wa),
        .wbe_i  (wbe),
        .din_i  (din),
        .re_i   (re),
        .ra_i   (ra),
        .rd_o   (rd1)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) v1_q <= 1'b0;
        else         v1_q <= re;
    end

    if (READ_MODE == READ_MODE_PIPE) begin : g_pipe
        logic [DATA_W-1:0] dout_q;
        logic              dout_valid_q;

        // oce=0 freezes the output stage; stage 1 keeps moving, so callers stall re with it.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else if (oce) begin
                dout_q       <= rd1;
                dout_valid_q <= v1_q;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end else begin : g_bypass
        logic unused_oce;
        assign unused_oce = oce;
        assign dout       = rd1;
        assign dout_valid = v1_q;
    end

endmodule
